// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller: load-use stall, redirect flush sequencing, memory freeze.
// Optional performance counters are enabled by defining HAZARD_CTRL_PERF_EN.
module hazard_ctrl #(
    parameter int FLUSH_EXTRA = 0,
    parameter int CNT_W       = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       id_rs1_i,
    input  logic [4:0]       id_rs2_i,
    input  logic             id_use_rs1_i,
    input  logic             id_use_rs2_i,
    input  logic [4:0]       ex_rd_i,
    input  logic             ex_memread_i,
    input  logic             ex_redirect_i,
    input  logic             mem_busy_i,
    output logic             pc_stall_o,
    output logic             ifid_stall_o,
    output logic             ifid_flush_o,
    output logic             idex_bubble_o,
    output logic             exmem_hold_o,
    output logic [CNT_W-1:0] busy_cycles_o,
    output logic [CNT_W-1:0] lu_stalls_o,
    output logic [CNT_W-1:0] flushes_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MEMW  = 2'd1,
        FLUSH = 2'd2
    } state_e;

    localparam logic [1:0] FCNT_INIT = (FLUSH_EXTRA > 0) ? 2'(FLUSH_EXTRA - 1) : 2'd0;

    state_e     st_q;
    logic [1:0] fcnt_q;

    logic lu;
    logic ev_busy, ev_redir, ev_lu, ev_flush;

    assign lu = ex_memread_i && (ex_rd_i != 5'd0) &&
                ((id_use_rs1_i && (id_rs1_i == ex_rd_i)) ||
                 (id_use_rs2_i && (id_rs2_i == ex_rd_i)));

    // One-hot priority decode: busy > redirect > load-use > flush tail.
    assign ev_busy  = !rst_i && mem_busy_i;
    assign ev_redir = !rst_i && !mem_busy_i && ex_redirect_i;
    assign ev_lu    = !rst_i && !mem_busy_i && !ex_redirect_i && lu;
    assign ev_flush = !rst_i && !mem_busy_i && !ex_redirect_i && !lu && (st_q == FLUSH);

    always_comb begin
        pc_stall_o    = 1'b0;
        ifid_stall_o  = 1'b0;
        ifid_flush_o  = 1'b0;
        idex_bubble_o = 1'b0;
        exmem_hold_o  = 1'b0;
        if (ev_busy) begin
            pc_stall_o   = 1'b1;
            ifid_stall_o = 1'b1;
            exmem_hold_o = 1'b1;
        end else if (ev_redir || ev_flush) begin
            ifid_flush_o  = 1'b1;
            idex_bubble_o = 1'b1;
        end else if (ev_lu) begin
            pc_stall_o    = 1'b1;
            ifid_stall_o  = 1'b1;
            idex_bubble_o = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            st_q   <= IDLE;
            fcnt_q <= 2'd0;
        end else if (ev_busy) begin
            st_q <= MEMW;
        end else if (ev_redir) begin
            if (FLUSH_EXTRA > 0) begin
                st_q   <= FLUSH;
                fcnt_q <= FCNT_INIT;
            end else begin
                st_q <= IDLE;
            end
        end else if (ev_lu) begin
            st_q <= st_q;
        end else if (ev_flush) begin
            if (fcnt_q == 2'd0) st_q <= IDLE;
            else                fcnt_q <= fcnt_q - 2'd1;
        end else begin
            st_q <= IDLE;
        end
    end

`ifdef HAZARD_CTRL_PERF_EN
    logic [CNT_W-1:0] busy_cnt_q, lu_cnt_q, fl_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_cnt_q <= '0;
            lu_cnt_q   <= '0;
            fl_cnt_q   <= '0;
        end else begin
            if (ev_busy  && busy_cnt_q != '1) busy_cnt_q <= busy_cnt_q + CNT_W'(1);
            if (ev_lu    && lu_cnt_q   != '1) lu_cnt_q   <= lu_cnt_q + CNT_W'(1);
            if (ev_redir && fl_cnt_q   != '1) fl_cnt_q   <= fl_cnt_q + CNT_W'(1);
        end
    end

    assign busy_cycles_o = busy_cnt_q;
    assign lu_stalls_o   = lu_cnt_q;
    assign flushes_o     = fl_cnt_q;
`else
    assign busy_cycles_o = '0;
    assign lu_stalls_o   = '0;
    assign flushes_o     = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized traffic against a behavioural model.
module tb_hazard_ctrl;
    localparam int FE    = 2;
    localparam int CNT_W = 2;

    logic clk = 1'b0;
    logic rst;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic id_use_rs1, id_use_rs2, ex_memread, ex_redirect, mem_busy;
    logic pc_stall, ifid_stall, ifid_flush, idex_bubble, exmem_hold;
    logic [CNT_W-1:0] busy_cycles, lu_stalls, flushes;

    int errors = 0;
    int checks = 0;

    // Model state: remaining extra flush cycles and raw event counts.
    int flush_left = 0;
    int n_busy = 0, n_lu = 0, n_fl = 0;
    logic [4:0] exp_o;
    logic [4:0] obs;

    always #5 clk = ~clk;

    hazard_ctrl #(.FLUSH_EXTRA(FE), .CNT_W(CNT_W)) dut (
        .clk_i(clk), .rst_i(rst),
        .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
        .id_use_rs1_i(id_use_rs1), .id_use_rs2_i(id_use_rs2),
        .ex_rd_i(ex_rd), .ex_memread_i(ex_memread),
        .ex_redirect_i(ex_redirect), .mem_busy_i(mem_busy),
        .pc_stall_o(pc_stall), .ifid_stall_o(ifid_stall), .ifid_flush_o(ifid_flush),
        .idex_bubble_o(idex_bubble), .exmem_hold_o(exmem_hold),
        .busy_cycles_o(busy_cycles), .lu_stalls_o(lu_stalls), .flushes_o(flushes)
    );

    // Output bundle order: {pc_stall, ifid_stall, ifid_flush, idex_bubble, exmem_hold}
    localparam logic [4:0] O_NONE  = 5'b00000;
    localparam logic [4:0] O_FREEZE = 5'b11001;
    localparam logic [4:0] O_FLUSH = 5'b00110;
    localparam logic [4:0] O_LU    = 5'b11010;

    assign obs = {pc_stall, ifid_stall, ifid_flush, idex_bubble, exmem_hold};

    function automatic logic [CNT_W-1:0] sat(input int n);
`ifdef HAZARD_CTRL_PERF_EN
        int mx = (1 << CNT_W) - 1;
        return (n > mx) ? CNT_W'(mx) : CNT_W'(n);
`else
        return '0;
`endif
    endfunction

    function automatic bit lu_now();
        return ex_memread && ex_rd != 0 &&
               ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    endfunction

    task automatic set_in(input logic r, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic u1, input logic u2, input logic [4:0] rd,
                          input logic mr, input logic rdr, input logic bsy);
        rst = r; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
        ex_rd = rd; ex_memread = mr; ex_redirect = rdr; mem_busy = bsy;
    endtask

    task automatic idle_in(input logic r);
        set_in(r, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // Expected stage controls for the current inputs, derived from the priority rules.
    task automatic predict();
        if (rst)                 exp_o = O_NONE;
        else if (mem_busy)       exp_o = O_FREEZE;
        else if (ex_redirect)    exp_o = O_FLUSH;
        else if (lu_now())       exp_o = O_LU;
        else if (flush_left > 0) exp_o = O_FLUSH;
        else                     exp_o = O_NONE;
        #1;
    endtask

    // Advance one clock and update the model; inputs change 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            flush_left = 0; n_busy = 0; n_lu = 0; n_fl = 0;
        end else if (mem_busy) begin
            flush_left = 0; n_busy++;
        end else if (ex_redirect) begin
            flush_left = FE; n_fl++;
        end else if (lu_now()) begin
            n_lu++;
        end else if (flush_left > 0) begin
            flush_left--;
        end
        #1;
    endtask

    task automatic test_reset();
        set_in(1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 5'd3, 1'b1, 1'b1, 1'b1);
        predict();
        checks++;
        if (obs !== O_NONE) begin errors++; $display("FAIL reset_outputs got=%b want=%b", obs, O_NONE); end
        tick();
        idle_in(1'b0);
        predict();
        checks++;
        if (obs !== O_NONE) begin errors++; $display("FAIL reset_after got=%b want=%b", obs, O_NONE); end
        checks++;
        if ({busy_cycles, lu_stalls, flushes} !== '0) begin
            errors++; $display("FAIL reset_counters got=%h want=0", {busy_cycles, lu_stalls, flushes});
        end
        tick();
    endtask

    task automatic test_load_use();
        logic [4:0] want [4] = '{O_LU, O_NONE, O_NONE, O_LU};
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: set_in(1'b0, 5'd5, 5'd1, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
                1: set_in(1'b0, 5'd5, 5'd1, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0);
                2: set_in(1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);
                default: set_in(1'b0, 5'd2, 5'd9, 1'b0, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
            endcase
            predict();
            checks++;
            if (obs !== want[i]) begin errors++; $display("FAIL load_use[%0d] got=%b want=%b", i, obs, want[i]); end
            tick();
        end
        idle_in(1'b0);
        tick();
    endtask

    task automatic test_redirect();
        logic [4:0] want [5] = '{O_FLUSH, O_FLUSH, O_FLUSH, O_NONE, O_NONE};
        for (int i = 0; i < 5; i++) begin
            idle_in(1'b0);
            ex_redirect = (i == 0);
            predict();
            checks++;
            if (obs !== want[i]) begin errors++; $display("FAIL redirect[%0d] got=%b want=%b", i, obs, want[i]); end
            tick();
        end
    endtask

    task automatic test_mem_freeze();
        for (int i = 0; i < 6; i++) begin
            idle_in(1'b0);
            ex_redirect = (i < 5);
            mem_busy = (i < 4);
            predict();
            checks++;
            if (obs !== ((i < 4) ? O_FREEZE : O_FLUSH)) begin
                errors++; $display("FAIL mem_freeze[%0d] got=%b want=%b", i, obs, (i < 4) ? O_FREEZE : O_FLUSH);
            end
            tick();
        end
        idle_in(1'b1);
        tick();
    endtask

    task automatic test_simultaneous();
        set_in(1'b0, 5'd7, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0);
        predict();
        checks++;
        if (obs !== O_FLUSH) begin errors++; $display("FAIL simultaneous got=%b want=%b", obs, O_FLUSH); end
        tick();
        idle_in(1'b1);
        tick();
    endtask

    task automatic test_reset_mid_flush();
        logic [4:0] want [4] = '{O_FLUSH, O_NONE, O_NONE, O_NONE};
        for (int i = 0; i < 4; i++) begin
            idle_in(i == 1 || i == 2);
            ex_redirect = (i == 0);
            predict();
            checks++;
            if (obs !== want[i]) begin errors++; $display("FAIL reset_mid_flush[%0d] got=%b want=%b", i, obs, want[i]); end
            tick();
        end
    endtask

    task automatic test_perf();
        logic [CNT_W-1:0] want_busy;
`ifdef HAZARD_CTRL_PERF_EN
        want_busy = 2'd3;
`else
        want_busy = 2'd0;
`endif
        idle_in(1'b1);
        tick();
        for (int i = 0; i < 5; i++) begin
            idle_in(1'b0);
            mem_busy = 1'b1;
            tick();
        end
        idle_in(1'b0);
        ex_redirect = 1'b1;
        tick();
        idle_in(1'b0);
        #1;
        checks++;
        if (busy_cycles !== want_busy) begin errors++; $display("FAIL perf_busy_sat got=%0d want=%0d", busy_cycles, want_busy); end
        checks++;
        if (flushes !== sat(1)) begin errors++; $display("FAIL perf_flushes got=%0d want=%0d", flushes, sat(1)); end
        checks++;
        if (lu_stalls !== '0) begin errors++; $display("FAIL perf_lu got=%0d want=0", lu_stalls); end
        tick();
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            set_in($urandom_range(0, 99) < 3,
                   5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)),
                   $urandom_range(0, 99) < 40, $urandom_range(0, 99) < 12,
                   $urandom_range(0, 99) < 20);
            predict();
            checks++;
            if (obs !== exp_o) begin errors++; $display("FAIL random[%0d] outputs got=%b want=%b", i, obs, exp_o); end
            tick();
            checks++;
            if ({busy_cycles, lu_stalls, flushes} !== {sat(n_busy), sat(n_lu), sat(n_fl)}) begin
                errors++;
                $display("FAIL random[%0d] counters got=%h want=%h", i,
                         {busy_cycles, lu_stalls, flushes}, {sat(n_busy), sat(n_lu), sat(n_fl)});
            end
        end
    endtask

    initial begin
        idle_in(1'b1);
        @(posedge clk);
        #1;
        test_reset();
        test_load_use();
        test_redirect();
        test_mem_freeze();
        test_simultaneous();
        test_reset_mid_flush();
        test_perf();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard/stall controller; drives the stall/bubble/flush inputs of the PC, IF/ID, ID/EX and EX/MEM stage registers.
- Detects load-use hazards between ID and EX.
- Sequences control-flow redirect flushes resolved in EX.
- Freezes the whole pipe while data memory is busy.
- Small registered FSM; all stage-control outputs are combinational from state plus inputs.

Parameters:
- FLUSH_EXTRA, 0, extra cycles (0..3) that ifid_flush stays high after a redirect, covering multi-cycle instruction fetch.
- CNT_W, 16, width of the performance counters (optional feature only).

Ports:
- clk  in  1  clock; rising edge.
- rst  in  1  reset; synchronous, active-high.
- id_rs1  in  5  rs1 index of the instruction in ID.
- id_rs2  in  5  rs2 index of the instruction in ID.
- id_use_rs1  in  1  ID instruction reads rs1.
- id_use_rs2  in  1  ID instruction reads rs2.
- ex_rd  in  5  rd of the instruction in EX.
- ex_memread  in  1  EX instruction is a load.
- ex_redirect  in  1  EX resolved a taken branch, jal or jalr; PC must load the target.
- mem_busy  in  1  data memory has not completed this cycle.
- pc_stall  out  1  hold PC.
- ifid_stall  out  1  hold IF/ID.
- ifid_flush  out  1  zero IF/ID (NOP).
- idex_bubble  out  1  ID/EX stall input: passes data, zeroes MemRead/MemWrite/RegWrite.
- exmem_hold  out  1  hold EX/MEM and MEM/WB.
- busy_cycles  out  CNT_W  optional: frozen-cycle count.
- lu_stalls  out  CNT_W  optional: load-use stall count.
- flushes  out  CNT_W  optional: redirect count.

Behaviour:
- State register st: IDLE, MEMW, FLUSH. Counter fcnt is 2 bits.
- While rst=1 at a clock edge: st<=IDLE, fcnt<=0, optional counters<=0.
- While rst=1, all control outputs are forced to 0 combinationally.
- Reset mid-operation abandons any MEMW or FLUSH sequence with no residual output the following cycle.
- Load-use condition lu: ex_memread & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)). ex_rd=x0 never stalls.
- Priority, evaluated every cycle: mem_busy > ex_redirect > lu > st==FLUSH > none.
- mem_busy=1 (any state):
  - pc_stall=ifid_stall=exmem_hold=1; idex_bubble=0, ifid_flush=0. This is a full freeze with no bubbles.
  - st<=MEMW; fcnt is preserved.
- Leaving MEMW when mem_busy=0: the normal rules below apply that same cycle; no dead cycle.
- ex_redirect=1 (mem_busy=0):
  - ifid_flush=1, idex_bubble=1, pc_stall=0 (PC loads target).
  - If FLUSH_EXTRA>0: st<=FLUSH, fcnt<=FLUSH_EXTRA-1. Else st<=IDLE.
  - A redirect arriving while in FLUSH restarts fcnt.
- lu=1 (no redirect, no busy):
  - pc_stall=ifid_stall=idex_bubble=1 for exactly that cycle; st unchanged.
  - Next cycle ex_memread=0 (bubbled), so the stall is self-limiting to 1 cycle.
- st==FLUSH, no higher-priority event:
  - ifid_flush=1, idex_bubble=1, pc_stall=0.
  - fcnt==0 -> st<=IDLE; else fcnt<=fcnt-1.
  - The redirect itself plus FLUSH_EXTRA cycles of ifid_flush are asserted in total.
- Redirect and lu in the same cycle: redirect wins; lu is ignored because the ID instruction is wrong-path.
- ex_redirect high during mem_busy: ignored until busy drops. EX is frozen, so the redirect is still presented.
- Outputs are never X after the first reset edge; all unlisted outputs are 0 in every case.
- Latency: combinational decode, zero-cycle from inputs to stage-control outputs.

Optional Feature:
- Macro HAZARD_CTRL_PERF_EN.
- Defined:
  - busy_cycles increments each cycle mem_busy=1.
  - lu_stalls increments each cycle a load-use stall is asserted.
  - flushes increments on each accepted redirect.
  - All three saturate at 2^CNT_W-1 and clear on rst.
- Undefined: the three ports remain and are tied to 0; no counter flops are synthesized.

Test Plan:
- Load-use: ex_memread=1, ex_rd=5, id_rs1=5, id_use_rs1=1 for one cycle -> pc_stall=ifid_stall=idex_bubble=1 that cycle only. With ex_rd=0 -> all outputs 0.
- Redirect, FLUSH_EXTRA=2: ex_redirect pulse 1 cycle -> ifid_flush=idex_bubble=1 for 3 consecutive cycles, pc_stall=0 throughout, then IDLE.
- Memory freeze: mem_busy=1 for 4 cycles with ex_redirect=1 held -> 4 cycles pc_stall=ifid_stall=exmem_hold=1, ifid_flush=0. On cycle 5, ifid_flush=1.
- Simultaneous: ex_redirect=1 and lu=1 same cycle -> ifid_flush=1, pc_stall=0 (redirect priority).
- Reset mid-FLUSH: assert rst on the 2nd flush cycle -> all outputs 0 while rst=1. The cycle after rst drops with idle inputs: outputs 0, st=IDLE.
- With HAZARD_CTRL_PERF_EN, CNT_W=2: 5 busy cycles -> busy_cycles=3 (saturated). Without the macro -> counter ports read 0.
